// File: rtl/hack_mem_arbiter_pkg.sv
// Shared constants and types for the Hack data-memory arbiter.
// Address map boundaries follow the Hack platform (RAM16K, screen, keyboard).
package hack_mem_arbiter_pkg;

  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;
  localparam logic        OWNER_A     = 1'b0;
  localparam logic        OWNER_B     = 1'b1;

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    OWN_A = OWNER_A,
    OWN_B = OWNER_B
  } owner_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
  } hack_req_t;

  // Writes are only allowed below the keyboard register.
  function automatic logic addr_writable(input logic [14:0] addr);
    return addr < KBD_ADDR;
  endfunction

endpackage

// File: rtl/hack_mem_arbiter_arb2_burst.sv
// Two-requester arbiter with a registered owner and a burst limit.
// Grants are combinational from the owner register, so at most one is ever high.
module arb2_burst
  import hack_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   a_req,
  input  logic   b_req,
  output owner_e owner,
  output logic   a_gnt,
  output logic   b_gnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] SAT  = '1;

  owner_e           r_owner;
  owner_e           w_owner_nxt;
  owner_e           w_other;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_own_req;
  logic             w_oth_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_owner <= OWN_A;
      r_cnt   <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_owner_nxt = r_owner;
    w_cnt_nxt   = '0;
    w_other     = (r_owner == OWN_A) ? OWN_B : OWN_A;
    w_own_req   = (r_owner == OWN_A) ? a_req : b_req;
    w_oth_req   = (r_owner == OWN_A) ? b_req : a_req;
    if (w_own_req) begin
      // The counter can run past LAST while the other side is idle, hence >=.
      if (w_oth_req && (r_cnt >= LAST)) begin
        w_owner_nxt = w_other;
      end else begin
        w_cnt_nxt = (r_cnt == SAT) ? r_cnt : r_cnt + 1'b1;
      end
    end else if (w_oth_req) begin
      w_owner_nxt = w_other;
    end
  end

  assign owner = r_owner;
  assign a_gnt = (r_owner == OWN_A) & a_req;
  assign b_gnt = (r_owner == OWN_B) & b_req;

endmodule

// File: rtl/hack_mem_arbiter.sv
// Shares the Hack data Memory port between the CPU (A) and a DMA/video engine (B).
// Holds the datapath mux, the keyboard-region write guard and the read-return registers.
module hack_mem_arbiter
  import hack_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW        = 15,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic [DW-1:0] mem_in,
  output logic [AW-1:0] mem_address,
  output logic          mem_load,
  input  logic [DW-1:0] mem_out,
  output logic          wr_err
);

  localparam int unsigned NP = 2;
  localparam logic [AW-1:0] KBD = AW'(KBD_ADDR);

  owner_e                  w_owner;
  logic                    w_sel;
  logic [NP-1:0]           w_gnt;
  logic [NP-1:0]           w_we;
  logic [NP-1:0][AW-1:0]   w_addr;
  logic [NP-1:0][DW-1:0]   w_wdata;
  logic [NP-1:0][DW-1:0]   w_rdata;
  logic [NP-1:0]           w_rvalid;
  logic                    w_granted;
  logic                    w_mem_we;
  logic                    w_writable;
  logic                    r_wr_err;

  arb2_burst #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clock (clock),
    .reset (reset),
    .a_req (a_req),
    .b_req (b_req),
    .owner (w_owner),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  assign w_sel   = (w_owner == OWN_B);
  assign w_gnt   = {b_gnt, a_gnt};
  assign w_we    = {b_we, a_we};
  assign w_addr  = {b_addr, a_addr};
  assign w_wdata = {b_wdata, a_wdata};

  // Owner steers the memory port even when it is not requesting; mem_load gates the write.
  assign mem_address = w_addr[w_sel];
  assign mem_in      = w_wdata[w_sel];
  assign w_mem_we    = w_we[w_sel];
  assign w_granted   = |w_gnt;
  assign w_writable  = (mem_address < KBD);
  assign mem_load    = w_granted & w_mem_we & w_writable;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_wr_err <= 1'b0;
    else       r_wr_err <= w_granted & w_mem_we & ~w_writable;
  end

  assign wr_err = r_wr_err;

  for (genvar p = 0; p < NP; p++) begin : g_port
    logic [DW-1:0] r_rdata;
    logic          r_rvalid;
    logic          w_rd;

    assign w_rd = w_gnt[p] & ~w_we[p];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_rd;
        if (w_rd) r_rdata <= mem_out;
      end
    end

    assign w_rdata[p]  = r_rdata;
    assign w_rvalid[p] = r_rvalid;
  end

  assign a_rdata  = w_rdata[0];
  assign a_rvalid = w_rvalid[0];
  assign b_rdata  = w_rdata[1];
  assign b_rvalid = w_rvalid[1];

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter with a behavioural Hack data Memory model.
module tb_hack_mem_arbiter;

  logic        clock, reset;
  logic        a_req, a_we, b_req, b_we;
  logic [14:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] mem_in, mem_out;
  logic [14:0] mem_address;
  logic        mem_load, wr_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ram [0:24575];

  hack_mem_arbiter #(.AW(15), .DW(16), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_in(mem_in), .mem_address(mem_address), .mem_load(mem_load),
    .mem_out(mem_out), .wr_err(wr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: RAM16K + screen below 0x6000, keyboard at 0x6000, zeros above.
  always @(posedge clock)
    if (mem_load && mem_address < 15'h6000) ram[mem_address] <= mem_in;

  always_comb begin
    mem_out = 16'h0000;
    if (mem_address < 15'h6000)       mem_out = ram[mem_address];
    else if (mem_address == 15'h6000) mem_out = 16'h0F0F;
  end

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    a_req = 1; b_req = 1;
    #1;
    n_tests++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_grants: a_gnt=%b b_gnt=%b expected 1 0", a_gnt, b_gnt);
    end
    n_tests++;
    if ({a_rvalid, b_rvalid, wr_err} !== 3'b000 || a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_regs: rv=%b%b wr_err=%b a_rdata=%h b_rdata=%h expected all 0",
               a_rvalid, b_rvalid, wr_err, a_rdata, b_rdata);
    end
    @(negedge clock);
    idle_inputs();
    reset = 0;
  endtask

  task automatic test_write_read();
    do_reset();
    a_req = 1; a_we = 1; a_addr = 15'h0010; a_wdata = 16'h1234;
    #1;
    n_tests++;
    if (a_gnt !== 1'b1 || mem_load !== 1'b1 || mem_address !== 15'h0010 || mem_in !== 16'h1234) begin
      n_fail++;
      $display("FAIL wr_cycle: gnt=%b load=%b addr=%h in=%h expected 1 1 0010 1234",
               a_gnt, mem_load, mem_address, mem_in);
    end
    @(negedge clock);
    a_we = 0;
    #1;
    n_tests++;
    if (a_gnt !== 1'b1 || mem_load !== 1'b0 || a_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_cycle: gnt=%b load=%b rvalid=%b expected 1 0 0", a_gnt, mem_load, a_rvalid);
    end
    @(negedge clock);
    idle_inputs();
    n_tests++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'h1234) begin
      n_fail++; $display("FAIL rd_return: rvalid=%b rdata=%h expected 1 1234", a_rvalid, a_rdata);
    end
    @(negedge clock);
    n_tests++;
    if (a_rvalid !== 1'b0 || a_rdata !== 16'h1234) begin
      n_fail++; $display("FAIL rd_hold: rvalid=%b rdata=%h expected 0 1234", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_b_switch();
    do_reset();
    @(negedge clock);
    b_req = 1; b_we = 0; b_addr = 15'h4000;
    #1;
    n_tests++;
    if (b_gnt !== 1'b0 || a_gnt !== 1'b0) begin
      n_fail++; $display("FAIL b_switch_wait: a_gnt=%b b_gnt=%b expected 0 0", a_gnt, b_gnt);
    end
    @(negedge clock);
    #1;
    n_tests++;
    if (b_gnt !== 1'b1 || mem_address !== 15'h4000 || mem_load !== 1'b0) begin
      n_fail++;
      $display("FAIL b_switch_gnt: b_gnt=%b addr=%h load=%b expected 1 4000 0", b_gnt, mem_address, mem_load);
    end
    @(negedge clock);
    idle_inputs();
    n_tests++;
    if (b_rvalid !== 1'b1 || b_rdata !== 16'hBEEF || a_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b_rd_return: b_rvalid=%b b_rdata=%h a_rvalid=%b expected 1 beef 0", b_rvalid, b_rdata, a_rvalid);
    end
  endtask

  task automatic test_burst();
    logic exp_a;
    int   wait_a, wait_b;
    do_reset();
    a_req = 1; a_addr = 15'h0010;
    b_req = 1; b_addr = 15'h4000;
    wait_a = 0; wait_b = 0;
    for (int i = 0; i < 12; i++) begin
      exp_a = ((i / 4) % 2) == 0;
      #1;
      n_tests++;
      if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
        n_fail++;
        $display("FAIL burst_seq[%0d]: a_gnt=%b b_gnt=%b expected %b %b", i, a_gnt, b_gnt, exp_a, !exp_a);
      end
      wait_a = a_gnt ? 0 : wait_a + 1;
      wait_b = b_gnt ? 0 : wait_b + 1;
      n_tests++;
      if (wait_a > 4 || wait_b > 4) begin
        n_fail++; $display("FAIL burst_wait[%0d]: wait_a=%0d wait_b=%0d limit 4", i, wait_a, wait_b);
      end
      @(negedge clock);
    end
    idle_inputs();
  endtask

  task automatic test_kbd_guard();
    do_reset();
    a_req = 1; a_we = 1; a_addr = 15'h5FFF; a_wdata = 16'hABCD;
    #1;
    n_tests++;
    if (a_gnt !== 1'b1 || mem_load !== 1'b1) begin
      n_fail++; $display("FAIL edge_5fff_load: gnt=%b load=%b expected 1 1", a_gnt, mem_load);
    end
    @(negedge clock);
    a_addr = 15'h6000; a_wdata = 16'hFFFF;
    n_tests++;
    if (wr_err !== 1'b0) begin
      n_fail++; $display("FAIL edge_5fff_err: wr_err=%b expected 0", wr_err);
    end
    #1;
    n_tests++;
    if (a_gnt !== 1'b1 || mem_load !== 1'b0) begin
      n_fail++; $display("FAIL kbd_wr_block: gnt=%b load=%b expected 1 0", a_gnt, mem_load);
    end
    @(negedge clock);
    a_we = 0;
    n_tests++;
    if (wr_err !== 1'b1) begin
      n_fail++; $display("FAIL kbd_wr_err: wr_err=%b expected 1", wr_err);
    end
    @(negedge clock);
    idle_inputs();
    n_tests++;
    if (wr_err !== 1'b0 || a_rvalid !== 1'b1 || a_rdata !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL kbd_rd: wr_err=%b rvalid=%b rdata=%h expected 0 1 0f0f", wr_err, a_rvalid, a_rdata);
    end
    n_tests++;
    if (ram[15'h5FFF] !== 16'hABCD) begin
      n_fail++; $display("FAIL edge_5fff_mem: mem=%h expected abcd", ram[15'h5FFF]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_req = 1; a_we = 0; a_addr = 15'h0010;
    b_req = 1; b_addr = 15'h4000;
    @(posedge clock);
    @(posedge clock);
    #3;
    n_tests++;
    if (a_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_rvalid: a_rvalid=%b expected 1", a_rvalid);
    end
    reset = 1;
    #1;
    n_tests++;
    if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || wr_err !== 1'b0 || a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rv=%b%b wr_err=%b gnt=%b%b expected 0 0 0 a=1 b=0",
               a_rvalid, b_rvalid, wr_err, a_gnt, b_gnt);
    end
    @(posedge clock);
    #1;
    n_tests++;
    if (a_rvalid !== 1'b0 || a_rdata !== 16'h0) begin
      n_fail++; $display("FAIL mid_hold: a_rvalid=%b a_rdata=%h expected 0 0000", a_rvalid, a_rdata);
    end
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_tests++;
      if (a_gnt !== (i < 4) || b_gnt !== (i >= 4)) begin
        n_fail++;
        $display("FAIL mid_resume[%0d]: a_gnt=%b b_gnt=%b expected %b %b", i, a_gnt, b_gnt, i < 4, i >= 4);
      end
      @(negedge clock);
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 24576; i++) ram[i] = 16'h0000;
    ram[15'h4000] = 16'hBEEF;
    test_reset();
    test_write_read();
    test_b_switch();
    test_burst();
    test_kbd_guard();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
